// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential signed multiplier.
// Provides the FSM state type and a wide conditional negate.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam int XW = 64;

  // Two's complement of x when en is set, else x unchanged.
  function automatic logic [XW-1:0] cond_neg(
    input logic [XW-1:0] x,
    input logic          en
  );
    return en ? (~x + 64'd1) : x;
  endfunction

endpackage

// File: rtl/mult_signed_seq_cond_neg.sv
// Conditional two's complement: y = en ? ~x+1 : x.
// Ports: x[W] in, en in, y[W] out (combinational).
module cond_neg #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic         en,
  output logic [W-1:0] y
);

  localparam logic [W-1:0] ONE = W'(1);

  assign y = en ? (~x + ONE) : x;

endmodule

// File: rtl/mult_signed_seq.sv
// Sequential N x M shift-add multiplier, signed/unsigned per op.
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready, A, B,
//   signed_mode, out_valid/out_ready, Prod, busy.
// Option: MULT_SEQ_EARLY_TERM_EN ends CALC once multiplier is zero.
module mult_signed_seq
  import mult_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [M-1:0]   B,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N+M-1:0] Prod,
  output logic           busy
);

  localparam int CNT_W = $clog2(M + 1);
  localparam int P_W   = N + M;

  state_t           state;
  logic [N-1:0]     mcand;
  logic [M-1:0]     mreg;
  logic [P_W-1:0]   acc;
  logic [CNT_W-1:0] cnt;
  logic             neg;

  logic             sign_a;
  logic             sign_b;
  logic [N-1:0]     mag_a;
  logic [M-1:0]     mag_b;
  logic [P_W-1:0]   fixed;

  logic [P_W-1:0]   addend;
  logic [CNT_W-1:0] cnt_nxt;
  logic [M-1:0]     mreg_sh;
  logic             last;

  assign sign_a = signed_mode & A[N-1];
  assign sign_b = signed_mode & B[M-1];

  cond_neg #(.W(N)) u_abs_a (
    .x  (A),
    .en (sign_a),
    .y  (mag_a)
  );

  cond_neg #(.W(M)) u_abs_b (
    .x  (B),
    .en (sign_b),
    .y  (mag_b)
  );

  cond_neg #(.W(P_W)) u_fix (
    .x  (acc),
    .en (neg),
    .y  (fixed)
  );

  // Shift cannot drop bits: max shift M-1 keeps mcand inside P_W.
  assign addend  = {{M{1'b0}}, mcand} << cnt;
  assign cnt_nxt = cnt + CNT_W'(1);
  assign mreg_sh = mreg >> 1;

`ifdef MULT_SEQ_EARLY_TERM_EN
  assign last = (cnt_nxt == CNT_W'(M)) || (mreg_sh == '0);
`else
  assign last = (cnt_nxt == CNT_W'(M));
`endif

  assign in_ready = rst_n && (state == IDLE);
  assign busy     = (state == CALC) || (state == FIX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand     <= '0;
      mreg      <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      out_valid <= 1'b0;
      Prod      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= mag_a;
            mreg  <= mag_b;
            neg   <= sign_a ^ sign_b;
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          if (mreg[0]) begin
            acc <= acc + addend;
          end
          mreg <= mreg_sh;
          cnt  <= cnt_nxt;
          if (last) begin
            state <= FIX;
          end
        end
        FIX: begin
          Prod      <= fixed;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_signed_seq.sv
// Self-checking bench for mult_signed_seq (N=4, M=5).
// Scoreboard queue of expected products, per-scenario tasks.
module tb_mult_signed_seq;
  import mult_pkg::*;

  localparam int N = 4;
  localparam int M = 5;
  localparam int P = N + M;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [M-1:0] B;
  logic         signed_mode;
  logic         out_valid;
  logic         out_ready;
  logic [P-1:0] Prod;
  logic         busy;

  int checks;
  int errors;
  logic [P-1:0] sb_q[$];

  mult_signed_seq #(.N(N), .M(M)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A           (A),
    .B           (B),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Prod        (Prod),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [P-1:0] model(
    input logic [N-1:0] a,
    input logic [M-1:0] b,
    input logic         sm
  );
    logic sa;
    logic sb;
    logic [63:0] ma;
    logic [63:0] mb;
    logic [63:0] p;
    sa = sm & a[N-1];
    sb = sm & b[M-1];
    ma = cond_neg(64'(a), sa) & ((64'd1 << N) - 64'd1);
    mb = cond_neg(64'(b), sb) & ((64'd1 << M) - 64'd1);
    p  = cond_neg(ma * mb, sa ^ sb);
    return p[P-1:0];
  endfunction

  function automatic int exp_lat(
    input logic [M-1:0] b,
    input logic         sm
  );
    logic [63:0] mb;
    int h;
    int lat;
    mb = cond_neg(64'(b), sm & b[M-1]);
    h = 0;
    for (int i = 0; i < M; i++)
      if (mb[i]) h = i;
    lat = M + 1;
`ifdef MULT_SEQ_EARLY_TERM_EN
    lat = h + 2;
`endif
    return lat;
  endfunction

  task automatic do_op(
    input logic [N-1:0] a,
    input logic [M-1:0] b,
    input logic         sm,
    input int           stall,
    input int           want_lat,
    input logic [P-1:0] want_p
  );
    int lat;
    int wt;
    logic [P-1:0] exp_p;
    @(negedge clk);
    wt = 0;
    while (!in_ready && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL op_ready: in_ready=%b want 1", in_ready);
      return;
    end
    A = a;
    B = b;
    signed_mode = sm;
    in_valid = 1'b1;
    sb_q.push_back(want_p);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = N'($urandom);
    B = M'($urandom);
    signed_mode = 1'($urandom);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL op_busy: busy=%b in_ready=%b want 1/0",
               busy, in_ready);
    end
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid === 1'b1) break;
    end
    exp_p = sb_q.pop_front();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL op_timeout: no out_valid after %0d cycles", lat);
      return;
    end
    checks++;
    if (lat !== want_lat) begin
      errors++;
      $display("FAIL op_latency a=%0d b=%0d sm=%0d: got %0d want %0d",
               a, b, sm, lat, want_lat);
    end
    checks++;
    if (Prod !== exp_p) begin
      errors++;
      $display("FAIL op_prod a=%0d b=%0d sm=%0d: got %h want %h",
               a, b, sm, Prod, exp_p);
    end
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      A = N'($urandom);
      B = M'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || Prod !== exp_p || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL op_stall: ov=%b prod=%h rdy=%b want 1/%h/0",
                 out_valid, Prod, in_ready, exp_p);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL op_release: ov=%b rdy=%b busy=%b want 0/1/0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    signed_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || Prod !== '0 || busy !== 1'b0 ||
        in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset: ov=%b prod=%h busy=%b rdy=%b want 0/0/0/0",
               out_valid, Prod, busy, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b busy=%b want 1/0",
               in_ready, busy);
    end
  endtask

  task automatic test_corners();
    do_op(4'b1000, 5'b10000, 1'b1, 0, exp_lat(5'b10000, 1'b1), 9'h080);
    do_op(4'd3, 5'b11011, 1'b1, 0, exp_lat(5'b11011, 1'b1), 9'h1F1);
    do_op(4'hF, 5'h1F, 1'b0, 0, exp_lat(5'h1F, 1'b0), 9'h1D1);
    do_op(4'hF, 5'h1F, 1'b1, 0, exp_lat(5'h1F, 1'b1), 9'h001);
  endtask

  task automatic test_backpressure();
    int seen;
    do_op(4'd7, 5'd9, 1'b0, 3, exp_lat(5'd9, 1'b0), 9'd63);
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL bp_ignored: %0d busy/valid cycles, want 0", seen);
    end
  endtask

  task automatic test_reset_mid_calc();
    int seen;
    @(negedge clk);
    A = 4'd5;
    B = 5'd7;
    signed_mode = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || Prod !== '0 || busy !== 1'b0 ||
        in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: ov=%b prod=%h busy=%b rdy=%b want 0/0/0/0",
               out_valid, Prod, busy, in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_rdy: in_ready=%b want 1", in_ready);
    end
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_mid_discard: %0d valid cycles, want 0", seen);
    end
    do_op(4'd2, 5'd2, 1'b0, 0, exp_lat(5'd2, 1'b0), 9'd4);
  endtask

  task automatic test_sweep();
    logic [N-1:0] a;
    logic [M-1:0] b;
    logic sm;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < (1 << N); i++) begin
        for (int j = 0; j < (1 << M); j++) begin
          a = N'(i);
          b = M'(j);
          sm = 1'(s);
          do_op(a, b, sm, $urandom_range(0, 3),
                exp_lat(b, sm), model(a, b, sm));
        end
      end
    end
  endtask

`ifdef MULT_SEQ_EARLY_TERM_EN
  task automatic test_early_term();
    do_op(4'd3, 5'd0, 1'b0, 0, 2, 9'd0);
    do_op(4'd5, 5'b00011, 1'b0, 0, 3, 9'd15);
    do_op(4'd1, 5'b10000, 1'b1, 0, 6, 9'h1F0);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_corners();
    test_backpressure();
    test_reset_mid_calc();
`ifdef MULT_SEQ_EARLY_TERM_EN
    test_early_term();
`endif
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
